// File: rtl/ts_pkg.sv
// Shared TS constants, write/read state encodings and a saturating counter helper.
// Used by the packet sync front end and by the merge stage downstream.
package ts_pkg;

  localparam logic [7:0] TS_SYNC   = 8'h47;
  localparam int         TS_LEN    = 188;
  localparam int         SLOT_AW   = 8;
  localparam int         RAM_AW    = SLOT_AW + 1;
  localparam int         RAM_DEPTH = 1 << RAM_AW;
  localparam logic [SLOT_AW-1:0] TS_LAST = SLOT_AW'(TS_LEN - 1);

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_COLLECT = 2'd1,
    W_DISCARD = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_RUN   = 2'd2
  } rd_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ts_pkt_ram.sv
// Two-slot packet store: simple dual-port 512x8, one write port, one read port.
// Registered read data, valid the cycle after re; no reset so contents survive rst.
module ts_pkt_ram
  import ts_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [RAM_AW-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem_q [RAM_DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ts_pkt_sync.sv
// Aligns a raw TS byte stream into clean 188-byte packets via a two-slot buffer.
// Output starts 3 cycles after the last input byte lands; no backpressure, full buffer drops packets.
module ts_pkt_sync
  import ts_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ts_din,
  input  logic        ts_din_en,
  output logic [7:0]  ts_dout,
  output logic        ts_dout_en,
  output logic        ts_dout_sop,
  output logic [15:0] pkt_ok_cnt,
  output logic [15:0] pkt_err_cnt
);

  wr_state_e          wr_st_q, wr_st_d;
  rd_state_e          rd_st_q, rd_st_d;
  logic [SLOT_AW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic               wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [1:0]         full_q, full_d;
  logic               b2b_q, b2b_d;
  logic               rd_vld_q, rd_vld_d, rd_first_q, rd_first_d;
  logic [7:0]         dout_q, dout_d;
  logic               dout_en_q, dout_en_d, sop_q, sop_d;
  logic [15:0]        ok_q, ok_d, err_q, err_d;
  logic               fill, free, ok_inc, err_inc;
  logic               ram_we, ram_re;
  logic [RAM_AW-1:0]  ram_waddr, ram_raddr;
  logic [7:0]         ram_rdata;

  ts_pkt_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ts_din),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    wr_st_d   = wr_st_q;
    wr_cnt_d  = wr_cnt_q;
    wr_slot_d = wr_slot_q;
    b2b_d     = 1'b0;
    fill      = 1'b0;
    ok_inc    = 1'b0;
    err_inc   = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = {wr_slot_q, wr_cnt_q};
    case (wr_st_q)
      W_IDLE: begin
        if (ts_din_en) begin
          if (ts_din == TS_SYNC && !full_q[wr_slot_q]) begin
            ram_we    = 1'b1;
            ram_waddr = {wr_slot_q, {SLOT_AW{1'b0}}};
            wr_cnt_d  = SLOT_AW'(1);
            wr_st_d   = W_COLLECT;
          end else begin
            // Idle garbage is silent; a broken back-to-back run or a start with no free slot loses a packet.
            err_inc = b2b_q || (ts_din == TS_SYNC);
            wr_st_d = W_DISCARD;
          end
        end
      end
      W_COLLECT: begin
        if (!ts_din_en) begin
          err_inc = 1'b1;
          wr_st_d = W_IDLE;
        end else begin
          ram_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + SLOT_AW'(1);
          if (wr_cnt_q == TS_LAST) begin
            fill      = 1'b1;
            ok_inc    = 1'b1;
            wr_slot_d = ~wr_slot_q;
            b2b_d     = 1'b1;
            wr_st_d   = W_IDLE;
          end
        end
      end
      W_DISCARD: if (!ts_din_en) wr_st_d = W_IDLE;
      default:   wr_st_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_st_d    = rd_st_q;
    rd_cnt_d   = rd_cnt_q;
    rd_slot_d  = rd_slot_q;
    rd_vld_d   = 1'b0;
    rd_first_d = 1'b0;
    free       = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = {rd_slot_q, rd_cnt_q};
    case (rd_st_q)
      // Holding off while the last byte is still in the RAM register keeps a 2-cycle gap between packets.
      R_IDLE: if (full_q[rd_slot_q] && !rd_vld_q) rd_st_d = R_START;
      R_START: begin
        ram_re     = 1'b1;
        ram_raddr  = {rd_slot_q, {SLOT_AW{1'b0}}};
        rd_vld_d   = 1'b1;
        rd_first_d = 1'b1;
        rd_cnt_d   = SLOT_AW'(1);
        rd_st_d    = R_RUN;
      end
      R_RUN: begin
        ram_re   = 1'b1;
        rd_vld_d = 1'b1;
        rd_cnt_d = rd_cnt_q + SLOT_AW'(1);
        if (rd_cnt_q == TS_LAST) begin
          free      = 1'b1;
          rd_slot_d = ~rd_slot_q;
          rd_st_d   = R_IDLE;
        end
      end
      default: rd_st_d = R_IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (fill) full_d[wr_slot_q] = 1'b1;
    if (free) full_d[rd_slot_q] = 1'b0;
    dout_d    = rd_vld_q ? ram_rdata : 8'h00;
    dout_en_d = rd_vld_q;
    sop_d     = rd_vld_q & rd_first_q;
    ok_d      = ok_inc  ? sat_inc16(ok_q)  : ok_q;
    err_d     = err_inc ? sat_inc16(err_q) : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_st_q    <= W_IDLE;
      rd_st_q    <= R_IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_slot_q  <= 1'b0;
      rd_slot_q  <= 1'b0;
      full_q     <= '0;
      b2b_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      dout_q     <= 8'h00;
      dout_en_q  <= 1'b0;
      sop_q      <= 1'b0;
      ok_q       <= '0;
      err_q      <= '0;
    end else begin
      wr_st_q    <= wr_st_d;
      rd_st_q    <= rd_st_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      full_q     <= full_d;
      b2b_q      <= b2b_d;
      rd_vld_q   <= rd_vld_d;
      rd_first_q <= rd_first_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
      sop_q      <= sop_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
    end
  end

  assign ts_dout     = dout_q;
  assign ts_dout_en  = dout_en_q;
  assign ts_dout_sop = sop_q;
  assign pkt_ok_cnt  = ok_q;
  assign pkt_err_cnt = err_q;

endmodule

// File: tb/tb_ts_pkt_sync.sv
// Directed bench for ts_pkt_sync: vector table of single bursts plus hand-built
// back-to-back, long-run and mid-packet reset sequences, checked against a byte scoreboard.
module tb_ts_pkt_sync;

  logic        clk;
  logic        rst;
  logic [7:0]  ts_din;
  logic        ts_din_en;
  logic [7:0]  ts_dout;
  logic        ts_dout_en;
  logic        ts_dout_sop;
  logic [15:0] pkt_ok_cnt;
  logic [15:0] pkt_err_cnt;

  ts_pkt_sync dut (
    .clk         (clk),
    .rst         (rst),
    .ts_din      (ts_din),
    .ts_din_en   (ts_din_en),
    .ts_dout     (ts_dout),
    .ts_dout_en  (ts_dout_en),
    .ts_dout_sop (ts_dout_sop),
    .pkt_ok_cnt  (pkt_ok_cnt),
    .pkt_err_cnt (pkt_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    logic       sop;
  } exp_t;

  typedef struct {
    int lead;   // garbage bytes before the sync byte
    int len;    // packet bytes driven
    int extra;  // one trailing non-sync byte in the same burst
    int kind;
    int fwd;    // packet expected at the output
    int d_ok;
    int d_err;
    int lat;    // check 3-cycle latency
  } vec_t;

  exp_t exp_q[$];
  vec_t vt[8];
  logic [7:0] garb[3];

  int n_chk = 0, n_pass = 0;
  int exp_ok = 0, exp_err = 0, exp_pkts = 0;
  int pkts_out = 0, in_pkt = 0, cur_len = 0, cur_bad = 0, gap = 1000;
  int lat_seq = 0, lat_seen = 0, lat_base = 0;

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  function automatic logic [7:0] pkt_byte(input int kind, input int i);
    logic [7:0] r;
    r = 8'(kind * 37 + i * 5);
    if (i == 0) r = 8'h47;
    else if (kind == 0) begin
      case (i)
        1: r = 8'h10;
        2: r = 8'h11;
        3: r = 8'h13;
        default: r = 8'(i - 3);
      endcase
    end else if (kind == 5) begin
      case (i)
        1: r = 8'h1F;
        2: r = 8'hFE;
        3: r = 8'h10;
        4: r = 8'h1A;
        5: r = 8'h86;
        default: r = 8'(i);
      endcase
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int kind);
    exp_t e;
    for (int i = 0; i < 188; i++) begin
      e.b   = pkt_byte(kind, i);
      e.sop = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_idle(input int n);
    ts_din_en = 1'b0;
    ts_din    = 8'h00;
    repeat (n) tick();
  endtask

  // rst_at >= 0 pulses reset on that byte and checks the cleared outputs one cycle later.
  task automatic drive_pkt(input int kind, input int len, input int rst_at, input int lat);
    for (int i = 0; i < len; i++) begin
      if (rst_at >= 0 && i == rst_at + 1) begin
        check("rst_dout_en", int'(ts_dout_en), 0);
        check("rst_dout", int'(ts_dout), 0);
        check("rst_sop", int'(ts_dout_sop), 0);
        check("rst_ok_cnt", int'(pkt_ok_cnt), 0);
        check("rst_err_cnt", int'(pkt_err_cnt), 0);
      end
      ts_din    = pkt_byte(kind, i);
      ts_din_en = 1'b1;
      rst       = (i == rst_at);
      tick();
    end
    rst = 1'b0;
    if (lat != 0) begin
      lat_base = cyc;
      lat_seq++;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        in_pkt  = 0;
        cur_len = 0;
        cur_bad = 0;
        gap     = 1000;
      end else if (ts_dout_en) begin
        if (in_pkt == 0) begin
          in_pkt  = 1;
          cur_len = 0;
          cur_bad = 0;
          n_chk++;
          if (gap >= 2) n_pass++;
          else $display("FAIL out_gap: got %0d idle cycles, expected at least 2", gap);
          if (lat_seq != lat_seen) begin
            check("latency", cyc - lat_base, 3);
            lat_seen = lat_seq;
          end
        end
        if (exp_q.size() == 0) cur_bad++;
        else begin
          e = exp_q.pop_front();
          if (e.b != ts_dout || e.sop != ts_dout_sop) cur_bad++;
        end
        cur_len++;
        gap = 0;
      end else begin
        if (in_pkt != 0) begin
          in_pkt = 0;
          pkts_out++;
          check("pkt_len", cur_len, 188);
          check("pkt_bad_bytes", cur_bad, 0);
        end
        if (ts_dout_sop) cur_bad++;
        gap++;
      end
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ok_cnt"}, int'(pkt_ok_cnt), exp_ok);
    check({tag, "_err_cnt"}, int'(pkt_err_cnt), exp_err);
    check({tag, "_pkts_out"}, pkts_out, exp_pkts);
  endtask

  initial begin
    //         lead len  ext kind fwd ok err lat
    vt[0] = '{0,   188, 0,  0,   1,  1, 0,  1};  // reference packet 47 10 11 13 01..B8
    vt[1] = '{0,   100, 0,  1,   0,  0, 1,  0};  // en drops after 100 bytes
    vt[2] = '{0,   188, 0,  2,   1,  1, 0,  1};
    vt[3] = '{3,   188, 0,  3,   0,  0, 0,  0};  // 00 55 AA lead-in poisons the burst
    vt[4] = '{0,   188, 0,  4,   1,  1, 0,  1};
    vt[5] = '{0,   188, 1,  6,   1,  1, 1,  1};  // one stray byte after a full packet
    vt[6] = '{0,   1,   0,  7,   0,  0, 1,  0};  // lone sync byte
    vt[7] = '{0,   187, 0,  8,   0,  0, 1,  0};  // one byte short
    garb[0] = 8'h00;
    garb[1] = 8'h55;
    garb[2] = 8'hAA;

    rst       = 1'b1;
    ts_din    = 8'h00;
    ts_din_en = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    check("reset_dout", int'(ts_dout), 0);
    check("reset_dout_en", int'(ts_dout_en), 0);
    check("reset_sop", int'(ts_dout_sop), 0);
    check("reset_ok_cnt", int'(pkt_ok_cnt), 0);
    check("reset_err_cnt", int'(pkt_err_cnt), 0);
    rst = 1'b0;
    drive_idle(5);

    for (int v = 0; v < 8; v++) begin
      if (vt[v].fwd != 0) push_exp(vt[v].kind);
      for (int g = 0; g < vt[v].lead; g++) begin
        ts_din    = garb[g % 3];
        ts_din_en = 1'b1;
        tick();
      end
      drive_pkt(vt[v].kind, vt[v].len, -1, vt[v].lat);
      if (vt[v].extra != 0) begin
        ts_din    = 8'h00;
        ts_din_en = 1'b1;
        tick();
      end
      drive_idle(220);
      exp_ok   += vt[v].d_ok;
      exp_err  += vt[v].d_err;
      exp_pkts += vt[v].fwd;
      check_counts($sformatf("vec%0d", v));
    end

    // Three packets in one 564-cycle burst: the third finds both slots occupied.
    push_exp(20);
    push_exp(21);
    drive_pkt(20, 188, -1, 1);
    drive_pkt(21, 188, -1, 0);
    drive_pkt(22, 188, -1, 0);
    drive_idle(450);
    exp_ok   += 2;
    exp_err  += 1;
    exp_pkts += 2;
    check_counts("b2b3");

    // TSMF header packet followed by 34 TS packets, 100 idle cycles apart.
    push_exp(5);
    drive_pkt(5, 188, -1, 0);
    drive_idle(100);
    for (int k = 0; k < 34; k++) begin
      push_exp(30 + k);
      drive_pkt(30 + k, 188, -1, 0);
      drive_idle(100);
    end
    drive_idle(200);
    exp_ok   += 35;
    exp_pkts += 35;
    check_counts("tsmf");

    // Reset while the previous packet is streaming out and the next is half written.
    push_exp(9);
    drive_pkt(9, 188, -1, 0);
    drive_pkt(7, 188, 90, 0);
    drive_idle(250);
    exp_ok  = 0;
    exp_err = 0;
    check_counts("post_rst");
    push_exp(11);
    drive_pkt(11, 188, -1, 1);
    drive_idle(220);
    exp_ok   += 1;
    exp_pkts += 1;
    check_counts("rst_recover");

    check("exp_left", exp_q.size(), 0);
    check("latency_seen", lat_seen, lat_seq);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
